// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller beside decode: tracks in-flight destination
// registers, raises load-use stalls and branch flushes, selects bypass data
// into execute and counts stall/flush cycles.
module pipeline_hazard_unit #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ADDR_W     = 3,
   parameter int unsigned FWD_DEPTH  = 3,
   parameter int unsigned LOAD_READY = 1,
   parameter int unsigned ZERO_REG   = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            id_valid,
   input  logic [ADDR_W-1:0]               id_rs1,
   input  logic [ADDR_W-1:0]               id_rs2,
   input  logic                            id_use_rs1,
   input  logic                            id_use_rs2,
   input  logic [ADDR_W-1:0]               id_rd,
   input  logic                            id_wb_en,
   input  logic                            id_is_load,
   input  logic [DATA_W-1:0]               rf_data1,
   input  logic [DATA_W-1:0]               rf_data2,
   input  logic [DATA_W*FWD_DEPTH-1:0]     stage_data,
   input  logic                            branch_taken,
   output logic                            stall,
   output logic                            flush,
   output logic [$clog2(FWD_DEPTH+1)-1:0]  fwd_sel1,
   output logic [$clog2(FWD_DEPTH+1)-1:0]  fwd_sel2,
   output logic [DATA_W-1:0]               ex_src1,
   output logic [DATA_W-1:0]               ex_src2,
   output logic [CNT_W-1:0]                stall_cnt,
   output logic [CNT_W-1:0]                flush_cnt
);

   localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);
   localparam int unsigned IDX_W = (FWD_DEPTH > 1) ? $clog2(FWD_DEPTH) : 1;

   typedef struct packed {
      logic              valid;
      logic              wb_en;
      logic [ADDR_W-1:0] rd;
      logic              is_load;
   } sb_entry_t;

   sb_entry_t [FWD_DEPTH-1:0] sb_q, sb_d;
   logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;

   logic [DATA_W-1:0] stage_arr [FWD_DEPTH];
   logic [ADDR_W-1:0] rs_a      [2];
   logic              use_a     [2];
   logic [DATA_W-1:0] rf_a      [2];
   logic              hit       [2];
   logic [IDX_W-1:0]  idx       [2];
   logic              blocked   [2];
   logic [SEL_W-1:0]  sel       [2];
   logic [DATA_W-1:0] src       [2];
   logic              hazard;

   // Unpack per-stage result bus
   for (genvar g = 0; g < FWD_DEPTH; g++) begin : g_stage
      assign stage_arr[g] = stage_data[g*DATA_W +: DATA_W];
   end

   assign rs_a[0]  = id_rs1;
   assign rs_a[1]  = id_rs2;
   assign use_a[0] = id_use_rs1;
   assign use_a[1] = id_use_rs2;
   assign rf_a[0]  = rf_data1;
   assign rf_a[1]  = rf_data2;

   function automatic logic src_match(input logic use_s, input logic [ADDR_W-1:0] rs,
                                      input sb_entry_t e);
      logic zero_blk;
      zero_blk = (ZERO_REG != 0) && (rs == '0);
      return use_s && e.valid && e.wb_en && (e.rd == rs) && !zero_blk;
   endfunction

   // Youngest-match lookup per source, load-use hazard and bypass mux
   always_comb begin
      hazard = 1'b0;
      for (int s = 0; s < 2; s++) begin
         hit[s]     = 1'b0;
         idx[s]     = '0;
         blocked[s] = 1'b0;
         sel[s]     = '0;
         src[s]     = rf_a[s];
         // scan oldest to youngest so the youngest match is left standing
         for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (src_match(use_a[s], rs_a[s], sb_q[i])) begin
               hit[s] = 1'b1;
               idx[s] = IDX_W'(i);
            end
         end
         blocked[s] = hit[s] && sb_q[idx[s]].is_load && (32'(idx[s]) < LOAD_READY);
         if (blocked[s]) hazard = 1'b1;
         if (hit[s] && !blocked[s] && !rst) begin
            sel[s] = SEL_W'(idx[s]) + SEL_W'(1);
            src[s] = stage_arr[idx[s]];
         end
      end
   end

   assign stall    = !rst && id_valid && hazard && !branch_taken;
   assign flush    = !rst && branch_taken;
   assign fwd_sel1 = sel[0];
   assign fwd_sel2 = sel[1];
   assign ex_src1  = src[0];
   assign ex_src2  = src[1];

   // Scoreboard shift and saturating performance counters
   always_comb begin
      sb_d        = sb_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      sb_d[0]     = '0;
      if (id_valid && !stall && !flush) begin
         sb_d[0] = '{valid: 1'b1, wb_en: id_wb_en, rd: id_rd, is_load: id_is_load};
      end
      for (int i = 1; i < FWD_DEPTH; i++) begin
         sb_d[i] = sb_q[i-1];
      end
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         sb_q        <= sb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
